debouncer_5ms: RTL and testbench

DEBOUNCER_5MS -- requirements
Module: debouncer_5ms

---
 rtl/debouncer_5ms.sv | 135 +++++++++++++
 tb/tb_debouncer_5ms.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/debouncer_5ms.sv
// Multi-channel push-button debouncer: two-flop synchronizer per input, then a
// per-channel FSM that accepts a new level after STABLE_TICKS agreeing Enable ticks.
module debouncer_5ms #(
  parameter int unsigned N_BTN        = 4,
  parameter int unsigned STABLE_TICKS = 4
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Enable,
  input  logic [N_BTN-1:0] Btn_in,
  output logic [N_BTN-1:0] Btn_level,
  output logic [N_BTN-1:0] Btn_press,
  output logic [N_BTN-1:0] Btn_release
);

  localparam int unsigned     CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  typedef enum logic [1:0] {
    LOW_STABLE  = 2'd0,
    RISE_CHECK  = 2'd1,
    HIGH_STABLE = 2'd2,
    FALL_CHECK  = 2'd3
  } state_t;

  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;

  // Synchronizer runs every clock, independent of the sampling tick.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= Btn_in;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < int'(N_BTN); g++) begin : g_chan
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_level;
    logic             w_level_nxt;
    logic             r_press;
    logic             w_press_nxt;
    logic             r_release;
    logic             w_release_nxt;
    logic             w_sync;

    assign w_sync = r_sync2[g];

    always_ff @(posedge CLK) begin
      if (Reset) begin
        r_state   <= LOW_STABLE;
        r_cnt     <= '0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_cnt     <= w_cnt_nxt;
        r_level   <= w_level_nxt;
        r_press   <= w_press_nxt;
        r_release <= w_release_nxt;
      end
    end

    // Pulses default low every cycle so they last exactly one clock.
    always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_level_nxt   = r_level;
      w_press_nxt   = 1'b0;
      w_release_nxt = 1'b0;
      if (Enable) begin
        case (r_state)
          LOW_STABLE: begin
            if (w_sync) begin
              w_state_nxt = RISE_CHECK;
              w_cnt_nxt   = CNT_W'(1);
            end else begin
              w_cnt_nxt   = '0;
            end
          end
          RISE_CHECK: begin
            if (!w_sync) begin
              w_state_nxt = LOW_STABLE;
              w_cnt_nxt   = '0;
            end else if (r_cnt >= CNT_LAST) begin
              w_state_nxt = HIGH_STABLE;
              w_cnt_nxt   = '0;
              w_level_nxt = 1'b1;
              w_press_nxt = 1'b1;
            end else begin
              w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
          end
          HIGH_STABLE: begin
            if (!w_sync) begin
              w_state_nxt = FALL_CHECK;
              w_cnt_nxt   = CNT_W'(1);
            end else begin
              w_cnt_nxt   = '0;
            end
          end
          FALL_CHECK: begin
            if (w_sync) begin
              w_state_nxt = HIGH_STABLE;
              w_cnt_nxt   = '0;
            end else if (r_cnt >= CNT_LAST) begin
              w_state_nxt   = LOW_STABLE;
              w_cnt_nxt     = '0;
              w_level_nxt   = 1'b0;
              w_release_nxt = 1'b1;
            end else begin
              w_cnt_nxt     = r_cnt + CNT_W'(1);
            end
          end
          default: begin
            w_state_nxt = LOW_STABLE;
            w_cnt_nxt   = '0;
          end
        endcase
      end
    end

    assign Btn_level[g]   = r_level;
    assign Btn_press[g]   = r_press;
    assign Btn_release[g] = r_release;
  end

endmodule

// File: tb/tb_debouncer_5ms.sv
// Directed plus randomized bench for debouncer_5ms against a run-length reference
// model: a level flips once STABLE_TICKS consecutive tick samples disagree with it.
module tb_debouncer_5ms;

  localparam int unsigned NB = 4;
  localparam int unsigned ST = 4;

  logic          CLK;
  logic          Reset;
  logic          Enable;
  logic [NB-1:0] Btn_in;
  logic [NB-1:0] Btn_level;
  logic [NB-1:0] Btn_press;
  logic [NB-1:0] Btn_release;

  debouncer_5ms #(.N_BTN(NB), .STABLE_TICKS(ST)) dut (
    .CLK(CLK),
    .Reset(Reset),
    .Enable(Enable),
    .Btn_in(Btn_in),
    .Btn_level(Btn_level),
    .Btn_press(Btn_press),
    .Btn_release(Btn_release)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_pass  = 0;
  int n_total = 0;

  // Reference state: two-clock delayed input, accepted level, disagreement run length.
  logic [NB-1:0] m_d1, m_d2, m_lvl, m_prs, m_rel;
  int            m_run [NB];
  logic [NB-1:0] seen_prs, seen_rel;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance model and DUT by one clock, then compare all outputs.
  task automatic step(input string tag);
    if (Reset) begin
      m_d1 = '0; m_d2 = '0; m_lvl = '0; m_prs = '0; m_rel = '0;
      for (int c = 0; c < int'(NB); c++) m_run[c] = 0;
    end else begin
      m_prs = '0;
      m_rel = '0;
      if (Enable) begin
        for (int c = 0; c < int'(NB); c++) begin
          if (m_d2[c] != m_lvl[c]) begin
            m_run[c]++;
            if (m_run[c] == int'(ST)) begin
              m_lvl[c] = ~m_lvl[c];
              if (m_lvl[c]) m_prs[c] = 1'b1;
              else          m_rel[c] = 1'b1;
              m_run[c] = 0;
            end
          end else begin
            m_run[c] = 0;
          end
        end
      end
      m_d2 = m_d1;
      m_d1 = Btn_in;
    end
    @(posedge CLK);
    #1;
    seen_prs |= Btn_press;
    seen_rel |= Btn_release;
    chk({tag, "_level"},   16'(Btn_level),   16'(m_lvl));
    chk({tag, "_press"},   16'(Btn_press),   16'(m_prs));
    chk({tag, "_release"}, 16'(Btn_release), 16'(m_rel));
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step("rst");
    step("rst");
    Reset = 1'b0;
  endtask

  initial begin
    Reset  = 1'b1;
    Enable = 1'b0;
    Btn_in = '0;
    seen_prs = '0;
    seen_rel = '0;
    m_d1 = '0; m_d2 = '0; m_lvl = '0; m_prs = '0; m_rel = '0;
    for (int c = 0; c < int'(NB); c++) m_run[c] = 0;
    #2;

    // Reset state
    do_reset();
    chk("reset_level", 16'(Btn_level), 16'h0);
    chk("reset_press", 16'(Btn_press), 16'h0);

    // Latency with Enable held high: accept after edge 6, pulse gone after edge 7
    Enable = 1'b1;
    Btn_in = 4'b0001;
    for (int e = 1; e <= 5; e++) step("lat");
    chk("lat_e5_level0", 16'(Btn_level[0]), 16'h0);
    step("lat");
    chk("lat_e6_level0", 16'(Btn_level[0]), 16'h1);
    chk("lat_e6_press0", 16'(Btn_press[0]), 16'h1);
    step("lat");
    chk("lat_e7_press0", 16'(Btn_press[0]), 16'h0);

    // Glitch of 2 ticks on channel 1 with Enable every 10 clocks
    seen_prs = '0;
    Btn_in[1] = 1'b1;
    for (int t = 0; t < 6; t++) begin
      if (t == 2) Btn_in[1] = 1'b0;
      Enable = 1'b1;
      step("glitch");
      Enable = 1'b0;
      repeat (9) step("glitch");
    end
    chk("glitch_level1", 16'(Btn_level[1]), 16'h0);
    chk("glitch_nopress1", 16'(seen_prs[1]), 16'h0);

    // Channel 2 high, then released over 4 spaced ticks
    Enable = 1'b1;
    Btn_in[2] = 1'b1;
    repeat (8) step("ch2_up");
    chk("ch2_high", 16'(Btn_level[2]), 16'h1);
    Enable = 1'b0;
    Btn_in[2] = 1'b0;
    step("ch2_sync");
    step("ch2_sync");
    for (int k = 1; k <= 4; k++) begin
      Enable = 1'b1;
      step("ch2_dn");
      if (k < 4) chk("ch2_hold_level", 16'(Btn_level[2]), 16'h1);
      else begin
        chk("ch2_rel_pulse", 16'(Btn_release[2]), 16'h1);
        chk("ch2_rel_level", 16'(Btn_level[2]), 16'h0);
      end
      Enable = 1'b0;
      step("ch2_gap");
      chk("ch2_rel_low", 16'(Btn_release[2]), 16'h0);
      repeat (8) step("ch2_gap");
    end

    // Channels 0 and 3 driven identically press together
    do_reset();
    Enable = 1'b1;
    Btn_in = 4'b1001;
    repeat (5) step("pair");
    step("pair");
    chk("pair_press", 16'(Btn_press), 16'h9);
    chk("pair_level", 16'(Btn_level), 16'h9);

    // Reset on the acceptance tick: no pulse, re-accept 6 edges after release
    do_reset();
    Enable = 1'b1;
    Btn_in = 4'b0001;
    repeat (5) step("rst_acc");
    seen_prs = '0;
    seen_rel = '0;
    Reset = 1'b1;
    step("rst_acc");
    chk("rst_acc_outs", 16'({Btn_level, Btn_press, Btn_release}), 16'h0);
    Reset = 1'b0;
    repeat (5) step("rst_acc");
    chk("rst_acc_nopulse", 16'({seen_prs[0], seen_rel[0]}), 16'h0);
    step("rst_acc");
    chk("rst_acc_press", 16'(Btn_press[0]), 16'h1);

    // Enable held low: toggling inputs never move the outputs
    do_reset();
    Enable = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      Btn_in = NB'($urandom);
      step("noen");
    end
    chk("noen_outs", 16'({Btn_level, Btn_press, Btn_release}), 16'h0);

    // Random mix of tick patterns, bouncy and held inputs, occasional reset
    for (int i = 0; i < 4000; i++) begin
      Reset  = ($urandom_range(0, 299) == 0);
      Enable = (i % 1000 < 500) ? ($urandom_range(0, 2) == 0) : 1'b1;
      for (int c = 0; c < int'(NB); c++)
        if ($urandom_range(0, 7) == 0) Btn_in[c] = ~Btn_in[c];
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
